pool_nl_ctrl: RTL and testbench

//  Sequences the pool/non-linearity datapath for one layer: latches layer config (nl_enable, nl_type,

---
 rtl/pool_nl_ctrl.sv | 147 ++++++++++++++
 tb/tb_pool_nl_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool_nl_ctrl.sv
// Layer sequencer for the pool/non-linearity lane: latches config, issues pixels under credit
// control, tracks the fixed-latency valid pipe. Optional POOL_NL_CTRL_PERF_EN adds a stall counter.
module pool_nl_ctrl #(
    parameter int unsigned NL_LAT  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_nl_enable,
    input  logic [2:0]       cfg_nl_type,
    input  logic [CNT_W-1:0] cfg_num_px,
    input  logic             cfg_abort,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
`ifdef POOL_NL_CTRL_PERF_EN
    output logic [CNT_W-1:0] perf_stall_cnt,
`endif
    input  logic             src_valid,
    output logic             src_ready,
    output logic             nl_enable,
    output logic [2:0]       nl_type,
    output logic             out_valid,
    input  logic             dst_pop
);

    localparam int unsigned OutW = $clog2(CREDITS + 1);
    localparam logic [OutW-1:0] CredMax = OutW'(CREDITS);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  num_px_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  issued_inc;
    logic [OutW-1:0]   outstanding_q, outstanding_d;
    logic [NL_LAT-1:0] pipe_q, pipe_d;
    logic              nl_enable_q;
    logic [2:0]        nl_type_q;
    logic              busy_q, done_q, err_q;
    logic              issue, start_acc, last_issue;

    // Abort wins over issue in the same cycle.
    assign issue      = (state_q == StRun) && src_valid && (outstanding_q < CredMax) && !cfg_abort;
    assign start_acc  = (state_q == StIdle) && cfg_start;
    assign issued_inc = issued_q + CNT_W'(1);
    assign last_issue = issue && (issued_inc == num_px_q);

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = issue;
        for (int unsigned i = 1; i < NL_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pop on an empty credit pool is dropped; issue+pop together cancel.
    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !dst_pop) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!issue && dst_pop && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    state_d = (cfg_num_px == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (cfg_abort || last_issue) begin
                    state_d = StDrain;
                end
            end
            // Leave as soon as the pipe will hold nothing next cycle.
            StDrain: begin
                if (pipe_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            num_px_q      <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            pipe_q        <= '0;
            nl_enable_q   <= 1'b0;
            nl_type_q     <= 3'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pipe_q        <= pipe_d;
            outstanding_q <= outstanding_d;
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_d == StDone);
            err_q         <= start_acc && (cfg_nl_type > 3'd1);
            if (start_acc) begin
                num_px_q    <= cfg_num_px;
                issued_q    <= '0;
                nl_enable_q <= cfg_nl_enable;
                nl_type_q   <= (cfg_nl_type > 3'd1) ? 3'd0 : cfg_nl_type;
            end else if (issue) begin
                issued_q <= issued_inc;
            end
        end
    end

`ifdef POOL_NL_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if ((state_q == StRun) && src_valid && !issue && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = stall_q;
`endif

    assign src_ready = issue;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign nl_enable = nl_enable_q;
    assign nl_type   = nl_type_q;
    assign out_valid = pipe_q[NL_LAT-1];

endmodule

// File: tb/tb_pool_nl_ctrl.sv
// Randomised bench for pool_nl_ctrl: a cycle-level behavioural model predicts issue, credits and
// layer timing; expected out_valid and cfg_done cycles go through scoreboard queues.
module tb_pool_nl_ctrl;

    localparam int NL_LAT  = 2;
    localparam int CNT_W   = 16;
    localparam int CREDITS = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_start, cfg_nl_enable, cfg_abort;
    logic [2:0]       cfg_nl_type;
    logic [CNT_W-1:0] cfg_num_px;
    logic             cfg_busy, cfg_done, cfg_err;
    logic             src_valid, src_ready, nl_enable, out_valid, dst_pop;
    logic [2:0]       nl_type;
`ifdef POOL_NL_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall_cnt;
`endif

    pool_nl_ctrl #(.NL_LAT(NL_LAT), .CNT_W(CNT_W), .CREDITS(CREDITS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_nl_enable (cfg_nl_enable),
        .cfg_nl_type   (cfg_nl_type),
        .cfg_num_px    (cfg_num_px),
        .cfg_abort     (cfg_abort),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
`ifdef POOL_NL_CTRL_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .nl_enable     (nl_enable),
        .nl_type       (nl_type),
        .out_valid     (out_valid),
        .dst_pop       (dst_pop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model state: layer progress, credit pool, expected event cycles.
    bit m_run, m_err_pend, m_en, mon_off;
    int m_issued, m_num, m_out, m_done_at, m_last_iss, m_type, m_stall;
    int q_out[$];
    int q_done[$];

    task automatic model_clear();
        m_run = 0; m_err_pend = 0; m_en = 0; m_type = 0; m_stall = 0;
        m_issued = 0; m_num = 0; m_out = 0; m_done_at = -1; m_last_iss = -100;
        q_out.delete();
        q_done.delete();
    endtask

    task automatic step(input bit st, input int num, input bit en, input int typ,
                        input bit valid, input bit ab, input bit pop);
        int  c;
        bit  idle, exp_rdy;
        @(negedge clk);
        cfg_start     = st;
        cfg_num_px    = num[CNT_W-1:0];
        cfg_nl_enable = en;
        cfg_nl_type   = typ[2:0];
        src_valid     = valid;
        cfg_abort     = ab;
        dst_pop       = pop;
        #1;
        c    = cyc;
        idle = !m_run && (c > m_done_at);
        chk("cfg_busy", int'(cfg_busy), int'(!idle));
        chk("cfg_err", int'(cfg_err), int'(m_err_pend));
        chk("nl_enable", int'(nl_enable), int'(m_en));
        chk("nl_type", int'(nl_type), m_type);
`ifdef POOL_NL_CTRL_PERF_EN
        chk("perf_stall_cnt", int'(perf_stall_cnt), m_stall);
`endif
        m_err_pend = 0;
        exp_rdy = m_run && valid && (m_out < CREDITS) && !ab;
        chk("src_ready", int'(src_ready), int'(exp_rdy));
        if (m_run && valid && !exp_rdy) m_stall++;
        if (exp_rdy) begin
            m_issued++;
            m_last_iss = c;
            q_out.push_back(c + NL_LAT);
        end
        if (exp_rdy && !pop) m_out++;
        else if (!exp_rdy && pop && m_out > 0) m_out--;
        if (m_run && (ab || m_issued == m_num)) begin
            // Done once drain has lasted a cycle and the last pixel has left the pipe.
            m_run     = 0;
            m_done_at = (c + 2 > m_last_iss + NL_LAT + 1) ? c + 2 : m_last_iss + NL_LAT + 1;
            q_done.push_back(m_done_at);
        end
        if (idle && st) begin
            m_en       = en;
            m_type     = (typ > 1) ? 0 : typ;
            m_err_pend = (typ > 1);
            m_stall    = 0;
            m_issued   = 0;
            m_num      = num;
            if (num == 0) begin
                m_done_at = c + 1;
                q_done.push_back(c + 1);
            end else begin
                m_run = 1;
            end
        end
    endtask

    int e_out, e_done;
    always @(negedge clk) begin
        #2;
        if (!mon_off && rst_n) begin
            if (out_valid) begin
                if (q_out.size() == 0) chk("out_valid_unexpected", int'(out_valid), 0);
                else begin
                    e_out = q_out.pop_front();
                    chk("out_valid_cycle", cyc, e_out);
                end
            end else if (q_out.size() > 0 && q_out[0] <= cyc) begin
                chk("out_valid_missing", int'(out_valid), 1);
                void'(q_out.pop_front());
            end
            if (cfg_done) begin
                if (q_done.size() == 0) chk("cfg_done_unexpected", int'(cfg_done), 0);
                else begin
                    e_done = q_done.pop_front();
                    chk("cfg_done_cycle", cyc, e_done);
                end
            end else if (q_done.size() > 0 && q_done[0] <= cyc) begin
                chk("cfg_done_missing", int'(cfg_done), 1);
                void'(q_done.pop_front());
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_src_ready", int'(src_ready), 0);
        chk("rst_cfg_busy", int'(cfg_busy), 0);
        chk("rst_cfg_done", int'(cfg_done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_nl_enable", int'(nl_enable), 0);
        chk("rst_nl_type", int'(nl_type), 0);
        chk("rst_out_valid", int'(out_valid), 0);
    endtask

    task automatic run_layer(input int num, input int typ, input bit en, input int valid_pct,
                             input int pop_pct, input int abort_at, input bit noise);
        int n, stuck;
        bit v, p, a, s;
        step(1, num, en, typ, int'($urandom % 100) < valid_pct, 0, 0);
        n = 0;
        stuck = 0;
        while ((m_run || (cyc + 1 <= m_done_at)) && n < 300) begin
            v = int'($urandom % 100) < valid_pct;
            p = int'($urandom % 100) < pop_pct;
            if (m_out >= CREDITS) stuck++;
            else stuck = 0;
            if (stuck > 6) p = 1;
            a = m_run ? (m_issued == abort_at) : ($urandom % 4 == 0);
            s = noise && ($urandom % 6 == 0);
            step(s, int'($urandom_range(0, 20)), bit'($urandom % 2), int'($urandom % 8), v, a, p);
            n++;
        end
        if (n >= 300) chk("layer_timeout", n, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        mon_off = 1'b1;
        {cfg_start, cfg_nl_enable, cfg_abort, src_valid, dst_pop} = '0;
        cfg_nl_type = '0;
        cfg_num_px  = '0;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        mon_off = 1'b0;

        run_layer(8, 1, 1, 100, 100, -1, 0);
        run_layer(0, 1, 1, 100, 100, -1, 0);
        run_layer(0, 5, 0, 100, 100, -1, 0);
        run_layer(3, 5, 1, 100, 100, -1, 0);
        run_layer(6, 1, 0, 100, 0, -1, 0);
        run_layer(10, 1, 1, 100, 100, 3, 1);
        repeat (3) step(0, 0, 0, 0, 1, bit'($urandom % 2), bit'($urandom % 2));

        for (int k = 0; k < 30; k++) begin
            run_layer(int'($urandom_range(0, 12)), int'($urandom % 8), bit'($urandom % 2),
                      int'($urandom_range(30, 100)), int'($urandom_range(20, 100)),
                      ($urandom % 3 == 0) ? int'($urandom_range(0, 8)) : -1, 1);
        end

        // Reset mid-run with pixels outstanding and in the pipe.
        step(1, 10, 1, 1, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        mon_off = 1'b1;
        #1;
        check_reset_outputs();
        model_clear();
        {cfg_start, cfg_abort, src_valid, dst_pop} = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_off = 1'b0;
        repeat (2) step(0, 0, 0, 0, 1, 0, 0);
        run_layer(5, 0, 1, 100, 50, -1, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);

        chk("out_queue_drained", q_out.size(), 0);
        chk("done_queue_drained", q_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
